prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Instruction-feed stage directly upstream of the 9-bit bus processor. It holds a small loadable program memory, drives the processor's `DIN` and `Run` inputs, and advances on the processor's `Done`. MVi immediates are supplied in the following cycle, and a HALT word stops the feed. A watchdog flags a processor that never returns `Done`.

## Interface
- `ADDR_W`, default 5: program memory address width; depth is 2^ADDR_W words.
- `DW`, default 9: instruction/data word width. Fixed at 9 to match the processor.
- `WD_LIMIT`, default 8: maximum number of WAIT cycles without `Done` before Error.

Ports:
- `Clock` input 1: single clock, rising edge.
- `Reset` input 1: synchronous, active-high.
- `Start` input 1: begin execution at address 0. Honoured only in IDLE or HALT.
- `Load_en` input 1: program write strobe. Honoured only in IDLE or HALT.
- `Load_addr` input ADDR_W: program write address.
- `Load_data` input DW: program write data.
- `Done` input 1: processor's Done output.
- `DIN` output DW: to processor `DIN`.
- `Run` output 1: to processor `Run`.
- `Busy` output 1: high in ISSUE, IMM and WAIT.
- `Halted` output 1: high in HALT.
- `Error` output 1: sticky watchdog flag. Cleared only by Reset or an accepted Start.
- `PC` output ADDR_W: current program address.
- `Instr_count` output 8: number of instructions issued, saturating at 255.

## Operation
- Memory:
  - 2^ADDR_W x DW register array with synchronous write; Reset does not clear it.
  - Read is asynchronous: `mem[PC]`.
- Opcode is `mem[PC][8:6]`.
  - 001 is MVi.
  - 111 is HALT; it is never issued to the processor.
  - All other opcodes are issued as ordinary instructions.
- States: IDLE, ISSUE, IMM, WAIT, HALT.
- IDLE:
  - `Run`=0, `DIN`=0.
  - On `Start`: PC←0, Instr_count←0, Error←0, go to ISSUE.
- ISSUE:
  - If opcode is HALT: `Run`=0, `DIN`=0, go to HALT; PC does not advance.
  - Otherwise: `DIN`=mem[PC], `Run`=1, PC←PC+1, Instr_count←Instr_count+1 (saturating).
  - Next state: IMM if opcode is MVi, else WAIT.
- IMM:
  - `DIN`=mem[PC] (the immediate), `Run`=0, PC←PC+1.
  - Next state is ISSUE. The processor's `Done` is expected in this cycle but is not checked.
- WAIT:
  - `DIN`=0, `Run`=0.
  - `Done`=1: go to ISSUE.
  - Otherwise the watchdog counter increments. When it reaches WD_LIMIT: Error←1, go to HALT.
  - The watchdog counter clears on entry to WAIT.
- HALT:
  - `Run`=0, `DIN`=0, `Halted`=1.
  - `Start` restarts exactly as from IDLE.
- PC arithmetic is modulo 2^ADDR_W; PC wraps from 2^ADDR_W−1 to 0 without error. An immediate at the last address is read from the top word and PC wraps to 0.
- `Start` and `Load_en` in the same cycle, both honoured: the write happens and the run starts; address 0 sees the new data only if written the cycle before.
- `Start` or `Load_en` while Busy: ignored; no state, memory or counter change.
- `Done` seen outside WAIT: ignored.

## Timing
- Reset (synchronous): state IDLE, PC=0, Instr_count=0, Error=0, watchdog=0. All outputs are 0 from the edge where Reset is sampled high.
- Reset wins over every other input in the same cycle. Reset mid-instruction abandons it; `Run` is low in the following cycle.
- Start → first `Run`=1: 1 cycle; ISSUE is entered at the edge that samples `Start`.
- `Run` is a one-cycle pulse, coincident with the processor's T0. `DIN` holds the opcode for that whole cycle.
- MVi: the immediate is on `DIN` in the cycle right after the `Run` pulse (processor T1). The next `Run` follows one cycle later.
  - Issue rate is one MVi per 2 cycles.
- MV: the processor returns `Done` in T1, the first WAIT cycle. The next `Run` follows one cycle later; issue rate is one per 2 cycles.
- ADD/SUB: `Done` arrives in the 3rd WAIT cycle; issue rate is one per 4 cycles.
- Watchdog: Error and HALT are taken at the edge ending the WD_LIMIT-th consecutive WAIT cycle with `Done`=0.

## Test plan
- Move test.
  - Stimulus: load 040h, 005h, 008h, 1C0h (MVi R0,#5; MV R1,R0; HALT); pulse Start.
  - Required: `Run` high in cycles 1 and 3; processor R0=5, R1=5; Halted=1, PC=3, Instr_count=2, Error=0.
- Add test.
  - Stimulus: program MVi R0,#3 / MVi R1,#4 / ADD R0,R1 (081h) / HALT.
  - Required: processor R0=7; exactly 3 WAIT cycles after the ADD issue; Instr_count=3.
- Watchdog test.
  - Stimulus: bench `Done` tied to 0; program 008h, HALT.
  - Required: Error=1 and Halted=1 exactly 8 cycles after the first WAIT cycle; `Run` stays 0 afterwards.
- Wrap test.
  - Stimulus: 32 words of 000h (MV R0,R0), no HALT; run 70 instructions.
  - Required: PC wraps 31→0; Instr_count=70; no Error.
  - Extension: run 300 instructions; Instr_count saturates at 255.
- Ignore-while-busy test.
  - Stimulus: `Load_en` to address 0 with 1C0h, and `Start`, both asserted while Busy.
  - Required: memory[0] unchanged, PC sequence unchanged.
  - Then Reset asserted mid-ADD: outputs 0 at the next edge, state IDLE.
- Restart test.
  - Stimulus: Start from HALT after an Error.
  - Required: Error clears, PC restarts at 0, program re-runs identically.

Source files
------------

// File: rtl/prog_sequencer.sv
// Instruction feed for the 9-bit bus processor: loadable program memory that drives DIN/Run,
// follows Done, supplies MVi immediates, stops on HALT and flags a processor that never finishes.
module prog_sequencer #(
    parameter int ADDR_W   = 5,
    parameter int DW       = 9,
    parameter int WD_LIMIT = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Load_en,
    input  logic [ADDR_W-1:0] Load_addr,
    input  logic [DW-1:0]     Load_data,
    input  logic              Done,
    output logic [DW-1:0]     DIN,
    output logic              Run,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [ADDR_W-1:0] PC,
    output logic [7:0]        Instr_count
);

    localparam int         DEPTH   = 1 << ADDR_W;
    localparam int         WD_W    = $clog2(WD_LIMIT + 1);
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_IMM   = 3'd2,
        S_WAIT  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    logic [DW-1:0]     mem_q [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [DW-1:0]     din_q, din_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              accept_s;
    logic [DW-1:0]     fetch_s;

    // Next-state and next-output computation
    always_comb begin
        accept_s = (state_q == S_IDLE) || (state_q == S_HALT);
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        wd_d     = wd_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    state_d = S_ISSUE;
                    pc_d    = '0;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_ISSUE: begin
                // Run was registered low on entry exactly when the fetched word is HALT
                if (!run_q) begin
                    state_d = S_HALT;
                end else begin
                    pc_d  = pc_q + ADDR_W'(1);
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    if (din_q[DW-1:DW-3] == OP_MVI) begin
                        state_d = S_IMM;
                    end else begin
                        state_d = S_WAIT;
                        wd_d    = '0;
                    end
                end
            end
            S_IMM: begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_ISSUE;
            end
            S_WAIT: begin
                if (Done) begin
                    state_d = S_ISSUE;
                end else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
                    wd_d    = wd_q + WD_W'(1);
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the word at the upcoming PC
        fetch_s  = mem_q[pc_d];
        run_d    = (state_d == S_ISSUE) && (fetch_s[DW-1:DW-3] != OP_HALT);
        din_d    = (run_d || (state_d == S_IMM)) ? fetch_s : '0;
        busy_d   = (state_d == S_ISSUE) || (state_d == S_IMM) || (state_d == S_WAIT);
        halted_d = (state_d == S_HALT);
    end

    // Sequencer state, counters and registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            cnt_q    <= 8'd0;
            err_q    <= 1'b0;
            wd_q     <= '0;
            din_q    <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
            din_q    <= din_d;
            run_q    <= run_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    // Program memory write port; contents survive Reset
    always_ff @(posedge Clock) begin
        if (!Reset && accept_s && Load_en) begin
            mem_q[Load_addr] <= Load_data;
        end
    end

    assign DIN         = din_q;
    assign Run         = run_q;
    assign Busy        = busy_q;
    assign Halted      = halted_q;
    assign Error       = err_q;
    assign PC          = pc_q;
    assign Instr_count = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: behavioural processor model, issue scoreboard and result table.
module tb_prog_sequencer;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic       Load_en;
    logic [4:0] Load_addr;
    logic [8:0] Load_data;
    logic       Done;
    logic [8:0] DIN;
    logic       Run;
    logic       Busy;
    logic       Halted;
    logic       Error;
    logic [4:0] PC;
    logic [7:0] Instr_count;

    prog_sequencer #(.ADDR_W(5), .DW(9), .WD_LIMIT(8)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Load_en(Load_en),
        .Load_addr(Load_addr), .Load_data(Load_data), .Done(Done),
        .DIN(DIN), .Run(Run), .Busy(Busy), .Halted(Halted), .Error(Error),
        .PC(PC), .Instr_count(Instr_count)
    );

    typedef struct {
        int         cyc;
        logic [8:0] din;
        logic [4:0] pc;
    } exp_t;

    typedef struct {
        int         nw;
        bit         done_en;
        bit         exp_err;
        int         exp_halt;
        logic [4:0] exp_pc;
        logic [7:0] exp_cnt;
        logic [8:0] exp_r0;
        logic [8:0] exp_r1;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[4];
    logic [8:0] progs[4][8];
    logic [8:0] tb_mem[32];
    logic [8:0] regs[8];
    logic [8:0] pir;
    int         pend;
    bit         tie_low;
    int         ncyc;
    int         issued;
    int         checks;
    int         failures;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Processor model and issue monitor, evaluated mid-cycle
    initial begin
        exp_t e;
        Done = 1'b0;
        pend = 0;
        forever begin
            @(negedge Clock);
            ncyc++;
            Done = 1'b0;
            if (Reset) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        case (pir[8:6])
                            3'b001: regs[pir[5:3]] = DIN;
                            3'b000: if (!tie_low) regs[pir[5:3]] = regs[pir[2:0]];
                            3'b010: if (!tie_low) regs[pir[5:3]] = regs[pir[5:3]] + regs[pir[2:0]];
                            3'b011: if (!tie_low) regs[pir[5:3]] = regs[pir[5:3]] - regs[pir[2:0]];
                            default: ;
                        endcase
                        if (!tie_low) Done = 1'b1;
                    end
                end
                if (Run === 1'b1) begin
                    pir  = DIN;
                    pend = (DIN[8:6] == 3'b010 || DIN[8:6] == 3'b011) ? 3 : 1;
                end
            end
            if (Run === 1'b1) begin
                issued++;
                if (sb.size() == 0) begin
                    check("unexpected_run", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("issue_cycle", ncyc, e.cyc);
                    check("issue_din", DIN, e.din);
                    check("issue_pc", PC, e.pc);
                end
            end
        end
    end

    // Expected issue stream: MVi/MV take 2 cycles, ADD/SUB 4, HALT is never issued
    task automatic gen_expect(input int s, input bit done_en, input int max_issue);
        logic [4:0] pc;
        logic [8:0] w;
        int t;
        int n;
        pc = 5'd0;
        t  = 1;
        n  = 0;
        while (n < max_issue) begin
            w = tb_mem[pc];
            if (w[8:6] == 3'b111) break;
            sb.push_back('{s + t, w, pc});
            n++;
            if (w[8:6] == 3'b001) begin
                pc = pc + 5'd2;
                t  = t + 2;
            end else begin
                if (!done_en) break;
                pc = pc + 5'd1;
                t  = t + ((w[8:6] == 3'b010 || w[8:6] == 3'b011) ? 4 : 2);
            end
        end
    endtask

    task automatic write_word(input logic [4:0] a, input logic [8:0] d);
        @(negedge Clock); #1;
        Load_en   = 1'b1;
        Load_addr = a;
        Load_data = d;
        tb_mem[a] = d;
        @(negedge Clock); #1;
        Load_en = 1'b0;
    endtask

    task automatic load_prog(input int i);
        for (int a = 0; a < vecs[i].nw; a++) write_word(5'(a), progs[i][a]);
    endtask

    task automatic begin_run(input bit done_en, input int max_issue, output int s);
        for (int r = 0; r < 8; r++) regs[r] = 9'd0;
        tie_low = !done_en;
        @(negedge Clock); #1;
        Start = 1'b1;
        s = ncyc;
        gen_expect(s, done_en, max_issue);
    endtask

    task automatic run_vec(input int i, input int poke_at);
        int s;
        int halt_at;
        halt_at = -1;
        begin_run(vecs[i].done_en, 64, s);
        for (int k = 1; k <= 200; k++) begin
            @(negedge Clock); #1;
            if (k == 1) begin
                Start = 1'b0;
                check("start_state", {Busy, Error, Halted, PC, Instr_count}, {1'b1, 1'b0, 1'b0, 5'd0, 8'd0});
            end
            if (poke_at > 0 && k == poke_at) begin
                check("poke_busy", Busy, 1'b1);
                Load_en   = 1'b1;
                Load_addr = 5'd0;
                Load_data = 9'h1C0;
                Start     = 1'b1;
            end else if (poke_at > 0 && k == poke_at + 1) begin
                Load_en = 1'b0;
                Start   = 1'b0;
            end
            if (Halted === 1'b1) begin
                halt_at = ncyc - s;
                break;
            end
        end
        check("halt_cycle", halt_at, vecs[i].exp_halt);
        check("error", Error, vecs[i].exp_err);
        check("pc_end", PC, vecs[i].exp_pc);
        check("instr_count", Instr_count, vecs[i].exp_cnt);
        check("idle_outputs", {Run, Busy, DIN}, 11'd0);
        check("reg_r0", regs[0], vecs[i].exp_r0);
        check("reg_r1", regs[1], vecs[i].exp_r1);
        check("sb_empty", sb.size(), 0);
    endtask

    task automatic reset_mid_add();
        int s;
        int i0;
        bit seen;
        seen = 1'b0;
        i0   = issued;
        begin_run(1'b1, 64, s);
        for (int k = 1; k <= 50; k++) begin
            @(negedge Clock); #1;
            if (k == 1) Start = 1'b0;
            if (issued - i0 == 3) begin
                seen = 1'b1;
                break;
            end
        end
        check("add_issued", seen, 1'b1);
        @(negedge Clock); #1;
        check("mid_add_busy", Busy, 1'b1);
        Reset = 1'b1;
        @(negedge Clock); #1;
        check("reset_mid_add", {DIN, Run, Busy, Halted, Error, PC, Instr_count}, 32'd0);
        Reset = 1'b0;
        repeat (4) @(negedge Clock);
        #1;
        check("idle_after_reset", {Run, Busy, Halted}, 3'd0);
        check("sb_empty_reset", sb.size(), 0);
    endtask

    task automatic wrap_test();
        int s;
        int i0;
        bit seen70;
        bit fin;
        seen70 = 1'b0;
        fin    = 1'b0;
        for (int a = 0; a < 32; a++) write_word(5'(a), 9'h000);
        i0 = issued;
        begin_run(1'b1, 300, s);
        for (int k = 1; k <= 700; k++) begin
            @(negedge Clock); #1;
            if (k == 1) Start = 1'b0;
            if (!seen70 && issued - i0 == 70 && Run === 1'b0) begin
                seen70 = 1'b1;
                check("count_70", Instr_count, 8'd70);
                check("pc_after_70", PC, 5'd6);
                check("no_error_70", Error, 1'b0);
            end
            if (issued - i0 == 300 && Run === 1'b0) begin
                fin = 1'b1;
                check("count_saturated", Instr_count, 8'd255);
                check("no_error_300", Error, 1'b0);
                break;
            end
        end
        check("wrap_finished", {seen70, fin}, 2'b11);
        Reset = 1'b1;
        @(negedge Clock); #1;
        Reset = 1'b0;
        check("wrap_reset", {DIN, Run, Busy, Halted, Error, PC, Instr_count}, 32'd0);
        check("sb_empty_wrap", sb.size(), 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ncyc     = 0;
        issued   = 0;
        tie_low  = 1'b0;
        Reset    = 1'b1;
        Start    = 1'b0;
        Load_en  = 1'b0;
        Load_addr = 5'd0;
        Load_data = 9'd0;

        progs = '{
            '{9'h040, 9'h005, 9'h008, 9'h1C0, 9'h000, 9'h000, 9'h000, 9'h000},
            '{9'h040, 9'h003, 9'h048, 9'h004, 9'h081, 9'h1C0, 9'h000, 9'h000},
            '{9'h040, 9'h009, 9'h048, 9'h004, 9'h0C1, 9'h1C0, 9'h000, 9'h000},
            '{9'h008, 9'h1C0, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000}
        };
        vecs[0] = '{4, 1'b1, 1'b0,  6, 5'd3, 8'd2, 9'd5, 9'd5};
        vecs[1] = '{6, 1'b1, 1'b0, 10, 5'd5, 8'd3, 9'd7, 9'd4};
        vecs[2] = '{6, 1'b1, 1'b0, 10, 5'd5, 8'd3, 9'd5, 9'd4};
        vecs[3] = '{2, 1'b0, 1'b1, 10, 5'd1, 8'd1, 9'd0, 9'd0};

        repeat (3) @(negedge Clock);
        #1;
        check("reset_outputs", {DIN, Run, Busy, Halted, Error, PC, Instr_count}, 32'd0);
        Reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            load_prog(i);
            run_vec(i, (i == 1) ? 2 : 0);
            // Restart from HALT re-runs the same program; a corrupted word 0 would show here
            if (i == 1) run_vec(1, 0);
        end
        run_vec(3, 0);

        load_prog(1);
        reset_mid_add();
        wrap_test();

        repeat (3) @(negedge Clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
